udp_frame_builder: RTL and testbench
====================================

// Module: udp_frame_builder
// PURPOSE
// Builds a complete Ethernet II / IPv4 / UDP frame into the 68 x 16-bit word buffer consumed by dm9000a.
// Accepts a streamed UDP payload, writes the fixed 42-byte header and computes the IPv4 header checksum.
// Presents packet/packet_length/clear_to_send and freezes the buffer until the controller acknowledges.
// Sits directly upstream of dm9000a in the ethernet path.
// PARAMETERS
// DST_MAC   48'hFFFF_FFFF_FFFF  destination MAC address
// SRC_MAC   48'h0060_6E90_0001  source MAC; must match the DM9000A EEPROM MAC
// SRC_IP    32'hC0A8_0102       IPv4 source address, 192.168.1.2
// DST_IP    32'hC0A8_0101       IPv4 destination address, 192.168.1.1
// SRC_PORT  16'd5000            UDP source port
// DST_PORT  16'd5001            UDP destination port
// TTL       8'd64               IPv4 time-to-live
// PORTS
// clk100         in   1        system clock, 100 MHz
// rst            in   1        synchronous reset, active-high
// start          in   1        1-cycle pulse: begin a frame; honoured only in IDLE
// payload_words  in   6        payload length in 16-bit words, sampled on start; values >47 saturate to 47
// pl_data        in   16       payload word, network byte order {first byte, second byte}
// pl_valid       in   1        pl_data valid
// pl_ready       out  1        builder accepts pl_data; a word transfers when pl_valid & pl_ready
// tx_ack         in   1        1-cycle pulse from the controller: frame fully consumed
// packet         out  16x68    frame buffer, packet[0..67]
// packet_length  out  16       frame length in bytes
// clear_to_send  out  1        buffer and packet_length valid and stable
// busy           out  1        high in every state except IDLE
// BEHAVIOUR
// - Reset values: pl_ready=0, clear_to_send=0, busy=0, packet_length=0, ip_id=0. Buffer contents after reset are don't-care.
// - Byte packing (DM9000A 16-bit mode, little-endian):
//   - packet[k][7:0] holds wire byte 2k; packet[k][15:8] holds wire byte 2k+1.
//   - Each payload word is therefore byte-swapped on store.
// - Header layout, words 0..20:
//   - Ethernet: DST_MAC, SRC_MAC, type 0x0800.
//   - IPv4: 0x4500; total_len = 28+2N; ip_id; 0x4000 (DF); {TTL, 8'd17}; checksum; SRC_IP; DST_IP.
//   - UDP: SRC_PORT, DST_PORT, udp_len = 8+2N, checksum 0x0000.
// - Payload word i is stored at packet[21+i]. Words 21+N..29 are written 0, so frames pad to 60 bytes.
// - packet_length = max(42+2N, 60), where N is the saturated payload_words.
// - FSM: IDLE -> LOAD -> HDR -> CSUM -> READY -> IDLE.
//   - IDLE: pl_ready=0. On start, latch N and go to LOAD; if N==0, go to HDR instead.
//   - LOAD: pl_ready=1. Each transfer stores one word. After the Nth transfer, pl_ready drops the next cycle and the FSM goes to HDR.
//   - HDR: 10 cycles. Writes all constant header words and the pad words. Adds one big-endian IPv4 header word per cycle (checksum field taken as 0) into a 17-bit accumulator with end-around carry.
//   - CSUM: 1 cycle. Folds the final carry, writes ~sum byte-swapped into packet[12], and loads packet_length.
//   - READY: clear_to_send=1. packet and packet_length are held constant. On tx_ack: clear_to_send=0 next cycle, ip_id increments (wraps 0xFFFF->0), FSM returns to IDLE.
// - Latency: if the last payload transfer is in cycle t, clear_to_send rises in cycle t+12. For N=0, clear_to_send rises 12 cycles after start.
// - Boundaries:
//   - start outside IDLE is ignored.
//   - pl_valid outside LOAD is ignored.
//   - tx_ack outside READY is ignored.
//   - start in the same cycle as tx_ack is ignored, because the FSM is still in READY.
//   - rst in any state returns to IDLE within 1 cycle and drops clear_to_send.
// STRUCTURE
// - ProtocolInfo package gains:
//   - ETHERTYPE_IPV4 = 16'h0800, IP_PROTO_UDP = 8'd17
//   - HDR_WORDS = 21, MAX_WORDS = 68, MAX_PAYLOAD_WORDS = 47, MIN_FRAME_BYTES = 60
//   - word offsets IP_CSUM_WORD = 12 and PAYLOAD_WORD = 21
//   - typedef frame_buf_t (logic [15:0] [0:67])
//   - enum builder_state_t
// - One sub-module: ip_checksum16. Interface: clear / add word / folded ~sum out. Reusable for a future RX checker.
// TESTING
// - N=0, default params -> packet_length=60; packet[12]==16'h7DB7 (checksum 0xB77D); words 21..29 zero; clear_to_send at start+12.
// - N=47, words 0x0100..0x012E with pl_valid held -> packet_length=136; packet[21]==16'h0001; packet[67]==16'h2E01; udp_len==102.
// - N=3 with pl_valid toggling every other cycle -> only handshaked words are stored, in order; packet_length=60; pad words 24..29 zero.
// - 3 frames, each tx_ack 5 cycles after clear_to_send -> ip_id 0,1,2 with checksums recomputed; start pulses during READY are ignored.
// - rst asserted mid-LOAD after 2 of 10 words -> clear_to_send=0, busy=0 next cycle; the next frame builds correctly.
// - payload_words=63 -> saturated to 47; packet_length=136; pl_ready drops after 47 transfers.

Source files
------------

// File: rtl/udp_frame_builder_pkg.sv
// Shared constants and types for the UDP/IPv4/Ethernet II frame builder.
package udp_frame_builder_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP      = 8'd17;
    localparam logic [15:0] IP_VER_IHL_TOS    = 16'h4500;
    localparam logic [15:0] IP_FLAGS_DF       = 16'h4000;

    localparam int          HDR_WORDS         = 32'd21;
    localparam int          MAX_WORDS         = 32'd68;
    localparam logic [5:0]  MAX_PAYLOAD_WORDS = 6'd47;
    localparam logic [15:0] MIN_FRAME_BYTES   = 16'd60;

    // word offsets inside the frame buffer
    localparam logic [6:0]  IP_CSUM_WORD      = 7'd12;
    localparam logic [6:0]  PAYLOAD_WORD      = 7'd21;
    localparam logic [6:0]  PAD_END_WORD      = 7'd29;
    localparam logic [4:0]  IP_HDR_WORD       = 5'd7;
    localparam logic [3:0]  HDR_LAST_CYCLE    = 4'd9;

    // packet[k] is one 16-bit word of the frame, k = 0..67
    typedef logic [0:MAX_WORDS-1][15:0] frame_buf_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HDR   = 3'd2,
        ST_CSUM  = 3'd3,
        ST_READY = 3'd4
    } builder_state_t;

    // network-order word {byte0, byte1} -> DM9000A little-endian word {byte1, byte0}
    function automatic logic [15:0] wire_order(input logic [15:0] be_word);
        return {be_word[7:0], be_word[15:8]};
    endfunction

endpackage

// File: rtl/udp_frame_builder_if.sv
// Payload stream, frame buffer and controller handshake of the frame builder.
interface udp_frame_builder_if;
    import udp_frame_builder_pkg::*;

    logic       start;
    logic [5:0] payload_words;
    logic [15:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       tx_ack;
    frame_buf_t packet;
    logic [15:0] packet_length;
    logic       clear_to_send;
    logic       busy;

    // producer/controller side
    modport master (
        output start, payload_words, pl_data, pl_valid, tx_ack,
        input  pl_ready, packet, packet_length, clear_to_send, busy
    );

    // frame builder side
    modport slave (
        input  start, payload_words, pl_data, pl_valid, tx_ack,
        output pl_ready, packet, packet_length, clear_to_send, busy
    );
endinterface

// File: rtl/udp_frame_builder_ip_checksum16.sv
// Running 16-bit one's-complement sum; csum is the folded, inverted result.
module ip_checksum16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] csum
);
    logic [16:0] acc_r;

    // accumulate with end-around carry; bit 16 holds the carry not yet folded
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 17'd0;
        end else if (clear) begin
            acc_r <= 17'd0;
        end else if (add) begin
            acc_r <= {1'b0, acc_r[15:0]} + {1'b0, word} + {16'd0, acc_r[16]};
        end else begin
            acc_r <= acc_r;
        end
    end

    // final fold cannot overflow: acc_r never reaches 17'h1FFFF from a cleared start
    assign csum = ~(acc_r[15:0] + {15'd0, acc_r[16]});

endmodule

// File: rtl/udp_frame_builder.sv
// Builds an Ethernet II / IPv4 / UDP frame into the DM9000A word buffer.
module udp_frame_builder
    import udp_frame_builder_pkg::*;
#(
    parameter logic [47:0] DST_MAC  = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC  = 48'h0060_6E90_0001,
    parameter logic [31:0] SRC_IP   = 32'hC0A8_0102,
    parameter logic [31:0] DST_IP   = 32'hC0A8_0101,
    parameter logic [15:0] SRC_PORT = 16'd5000,
    parameter logic [15:0] DST_PORT = 16'd5001,
    parameter logic [7:0]  TTL      = 8'd64
) (
    input  logic               clk100,
    input  logic               rst,
    udp_frame_builder_if.slave bus
);
    builder_state_t     state_r;
    logic [5:0]         n_r;
    logic [5:0]         wr_idx_r;
    logic [3:0]         hdr_cnt_r;
    logic [15:0]        ip_id_r;
    logic               pl_ready_r;
    logic               cts_r;
    logic               busy_r;
    logic [15:0]        pkt_len_r;
    frame_buf_t         packet_r;

    logic [5:0]         n_sat_s;
    logic               xfer_s;
    logic [6:0]         pl_idx_s;
    logic [6:0]         pad_from_s;
    logic [4:0]         ip_idx_s;
    logic [15:0]        total_len_s;
    logic [15:0]        udp_len_s;
    logic [15:0]        frame_bytes_s;
    logic [0:20][15:0]  hdr_be_s;
    logic [15:0]        csum_s;

    assign xfer_s        = (state_r == ST_LOAD) && bus.pl_valid && pl_ready_r;
    assign pl_idx_s      = PAYLOAD_WORD + {1'b0, wr_idx_r};
    assign pad_from_s    = PAYLOAD_WORD + {1'b0, n_r};
    assign ip_idx_s      = IP_HDR_WORD + {1'b0, hdr_cnt_r};
    assign total_len_s   = 16'd28 + {9'd0, n_r, 1'b0};
    assign udp_len_s     = 16'd8  + {9'd0, n_r, 1'b0};
    assign frame_bytes_s = 16'd42 + {9'd0, n_r, 1'b0};

    // clamp the requested payload length to what fits in the buffer
    always_comb begin
        if (bus.payload_words > MAX_PAYLOAD_WORDS) begin
            n_sat_s = MAX_PAYLOAD_WORDS;
        end else begin
            n_sat_s = bus.payload_words;
        end
    end

    // header words 0..20 in network order; IPv4 checksum field left at zero
    always_comb begin
        hdr_be_s = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4,
                    IP_VER_IHL_TOS, total_len_s, ip_id_r, IP_FLAGS_DF,
                    TTL, IP_PROTO_UDP, 16'h0000, SRC_IP, DST_IP,
                    SRC_PORT, DST_PORT, udp_len_s, 16'h0000};
    end

    ip_checksum16 u_csum (
        .clk   (clk100),
        .rst   (rst),
        .clear (bus.start && (state_r == ST_IDLE)),
        .add   (state_r == ST_HDR),
        .word  (hdr_be_s[ip_idx_s]),
        .csum  (csum_s)
    );

    // frame sequencing: load payload, write header, finish checksum, hold for controller
    always_ff @(posedge clk100) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            n_r        <= 6'd0;
            wr_idx_r   <= 6'd0;
            hdr_cnt_r  <= 4'd0;
            ip_id_r    <= 16'd0;
            pl_ready_r <= 1'b0;
            cts_r      <= 1'b0;
            busy_r     <= 1'b0;
            pkt_len_r  <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        n_r       <= n_sat_s;
                        wr_idx_r  <= 6'd0;
                        hdr_cnt_r <= 4'd0;
                        busy_r    <= 1'b1;
                        if (n_sat_s == 6'd0) begin
                            state_r <= ST_HDR;
                        end else begin
                            state_r    <= ST_LOAD;
                            pl_ready_r <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        wr_idx_r <= wr_idx_r + 6'd1;
                        if (wr_idx_r == (n_r - 6'd1)) begin
                            pl_ready_r <= 1'b0;
                            state_r    <= ST_HDR;
                        end
                    end
                end
                ST_HDR: begin
                    hdr_cnt_r <= hdr_cnt_r + 4'd1;
                    if (hdr_cnt_r == HDR_LAST_CYCLE) begin
                        state_r <= ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    state_r <= ST_READY;
                    cts_r   <= 1'b1;
                    if (frame_bytes_s < MIN_FRAME_BYTES) begin
                        pkt_len_r <= MIN_FRAME_BYTES;
                    end else begin
                        pkt_len_r <= frame_bytes_s;
                    end
                end
                ST_READY: begin
                    if (bus.tx_ack) begin
                        cts_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        ip_id_r <= ip_id_r + 16'd1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    pl_ready_r <= 1'b0;
                    cts_r      <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // buffer writes; nothing touches the buffer in IDLE or READY, so it stays frozen
    always_ff @(posedge clk100) begin
        if (xfer_s) begin
            packet_r[pl_idx_s] <= wire_order(bus.pl_data);
        end else if (state_r == ST_HDR) begin
            for (logic [4:0] k = 5'd0; k < 5'd21; k++) begin
                packet_r[{2'b00, k}] <= wire_order(hdr_be_s[k]);
            end
            for (logic [6:0] k = PAYLOAD_WORD; k <= PAD_END_WORD; k++) begin
                if (k >= pad_from_s) begin
                    packet_r[k] <= 16'h0000;
                end
            end
        end else if (state_r == ST_CSUM) begin
            packet_r[IP_CSUM_WORD] <= wire_order(csum_s);
        end
    end

    assign bus.pl_ready      = pl_ready_r;
    assign bus.clear_to_send = cts_r;
    assign bus.busy          = busy_r;
    assign bus.packet_length = pkt_len_r;
    assign bus.packet        = packet_r;

endmodule

// File: tb/tb_udp_frame_builder.sv
// Scoreboard bench for udp_frame_builder: expected frames are queued at start
// and compared word-by-word when clear_to_send rises.
module tb_udp_frame_builder;

    logic clk100 = 1'b0;
    logic rst;

    udp_frame_builder_if bus();

    udp_frame_builder dut (
        .clk100 (clk100),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk100 = ~clk100;

    typedef struct {
        logic [15:0] w [68];
        int          nw;
        logic [15:0] len;
    } frame_t;

    frame_t      sb[$];
    frame_t      mon_f;
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] exp_ip_id;
    logic        cts_q = 1'b0;
    logic [15:0] pl [47];

    always @(posedge clk100) cyc <= cyc + 1;

    // reference frame: big-endian header, 32-bit one's-complement sum, then byte swap
    function automatic frame_t model(input int n_in, input logic [15:0] id);
        frame_t      f;
        logic [15:0] be [68];
        logic [31:0] s;
        int          n;
        n = (n_in > 47) ? 47 : n_in;
        for (int k = 0; k < 68; k++) be[k] = 16'h0000;
        be[0] = 16'hFFFF; be[1] = 16'hFFFF; be[2] = 16'hFFFF;
        be[3] = 16'h0060; be[4] = 16'h6E90; be[5] = 16'h0001;
        be[6] = 16'h0800;
        be[7] = 16'h4500; be[8] = 16'(28 + 2 * n); be[9] = id; be[10] = 16'h4000;
        be[11] = 16'h4011; be[12] = 16'h0000;
        be[13] = 16'hC0A8; be[14] = 16'h0102; be[15] = 16'hC0A8; be[16] = 16'h0101;
        be[17] = 16'd5000; be[18] = 16'd5001; be[19] = 16'(8 + 2 * n); be[20] = 16'h0000;
        s = 32'd0;
        for (int k = 7; k <= 16; k++) s = s + {16'h0000, be[k]};
        while (s[31:16] != 16'h0000) s = {16'h0000, s[15:0]} + {16'h0000, s[31:16]};
        be[12] = ~s[15:0];
        for (int i = 0; i < n; i++) be[21 + i] = pl[i];
        for (int k = 0; k < 68; k++) f.w[k] = {be[k][7:0], be[k][15:8]};
        f.nw  = (21 + n > 30) ? (21 + n) : 30;
        f.len = (42 + 2 * n > 60) ? 16'(42 + 2 * n) : 16'd60;
        return f;
    endfunction

    // scoreboard: compare the whole defined part of the buffer when clear_to_send rises
    always @(negedge clk100) begin
        if (bus.clear_to_send === 1'b1 && cts_q !== 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++; n_bad++;
                $display("FAIL sb_empty: clear_to_send rose at cycle %0d with no frame expected", cyc);
            end else begin
                mon_f = sb.pop_front();
                for (int k = 0; k < mon_f.nw; k++) begin
                    n_vec++;
                    if (bus.packet[k] !== mon_f.w[k]) begin
                        n_bad++;
                        $display("FAIL sb_word[%0d]: got %h expected %h", k, bus.packet[k], mon_f.w[k]);
                    end
                end
                n_vec++;
                if (bus.packet_length !== mon_f.len) begin
                    n_bad++;
                    $display("FAIL sb_length: got %0d expected %0d", bus.packet_length, mon_f.len);
                end
            end
        end
        cts_q = bus.clear_to_send;
    end

    task automatic apply_reset();
        bus.start = 1'b0; bus.payload_words = 6'd0; bus.pl_data = 16'h0000;
        bus.pl_valid = 1'b0; bus.tx_ack = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk100);
        rst = 1'b0;
        sb.delete();
        exp_ip_id = 16'd0;
    endtask

    task automatic start_frame(input logic [5:0] pw, output int s_cyc);
        sb.push_back(model(int'(pw), exp_ip_id));
        bus.payload_words = pw;
        bus.start = 1'b1;
        s_cyc = cyc;
        @(negedge clk100);
        bus.start = 1'b0;
    endtask

    task automatic send_payload(input int n, input bit toggle, output int sent, output int last);
        bit ph;
        int g;
        sent = 0; last = 0; ph = 1'b0; g = 0;
        while (sent < n && g < 400) begin
            bus.pl_valid = toggle ? ph : 1'b1;
            bus.pl_data  = bus.pl_valid ? pl[sent] : 16'hDEAD;
            if (bus.pl_valid && bus.pl_ready) begin
                sent++;
                last = cyc;
            end
            ph = ~ph;
            @(negedge clk100);
            g++;
        end
        bus.pl_valid = 1'b0;
    endtask

    task automatic wait_cts(output int c, output bit ok);
        int g;
        g = 0;
        while (bus.clear_to_send !== 1'b1 && g < 200) begin
            @(negedge clk100);
            g++;
        end
        ok = (bus.clear_to_send === 1'b1);
        c  = cyc;
    endtask

    task automatic do_ack(input bit with_start);
        bus.tx_ack = 1'b1;
        bus.start  = with_start;
        @(negedge clk100);
        bus.tx_ack = 1'b0;
        bus.start  = 1'b0;
        exp_ip_id  = exp_ip_id + 16'd1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (bus.pl_ready !== 1'b0)      begin n_bad++; $display("FAIL reset_pl_ready: got %b expected 0", bus.pl_ready); end
        n_vec++; if (bus.clear_to_send !== 1'b0) begin n_bad++; $display("FAIL reset_cts: got %b expected 0", bus.clear_to_send); end
        n_vec++; if (bus.busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.packet_length !== 16'd0) begin n_bad++; $display("FAIL reset_length: got %0d expected 0", bus.packet_length); end
    endtask

    task automatic test_min_frame();
        int s, c;
        bit ok;
        start_frame(6'd0, s);
        n_vec++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL min_busy: got %b expected 1", bus.busy); end
        wait_cts(c, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL min_timeout: clear_to_send never rose"); end
        n_vec++; if (c - s !== 12) begin n_bad++; $display("FAIL min_latency: got %0d expected 12", c - s); end
        n_vec++; if (bus.packet_length !== 16'd60) begin n_bad++; $display("FAIL min_length: got %0d expected 60", bus.packet_length); end
        n_vec++; if (bus.packet[12] !== 16'h7DB7) begin n_bad++; $display("FAIL min_csum: got %h expected 7db7", bus.packet[12]); end
        for (int k = 21; k <= 29; k++) begin
            n_vec++;
            if (bus.packet[k] !== 16'h0000) begin n_bad++; $display("FAIL min_pad[%0d]: got %h expected 0000", k, bus.packet[k]); end
        end
        do_ack(1'b0);
        n_vec++; if (bus.clear_to_send !== 1'b0) begin n_bad++; $display("FAIL min_ack_cts: got %b expected 0", bus.clear_to_send); end
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL min_ack_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_max_frame();
        int s, c, sent, last;
        bit ok;
        for (int i = 0; i < 47; i++) pl[i] = 16'h0100 + 16'(i);
        start_frame(6'd47, s);
        send_payload(47, 1'b0, sent, last);
        n_vec++; if (sent !== 47) begin n_bad++; $display("FAIL max_sent: got %0d expected 47", sent); end
        n_vec++; if (bus.pl_ready !== 1'b0) begin n_bad++; $display("FAIL max_ready_drop: got %b expected 0", bus.pl_ready); end
        wait_cts(c, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL max_timeout: clear_to_send never rose"); end
        n_vec++; if (c - last !== 12) begin n_bad++; $display("FAIL max_latency: got %0d expected 12", c - last); end
        n_vec++; if (bus.packet_length !== 16'd136) begin n_bad++; $display("FAIL max_length: got %0d expected 136", bus.packet_length); end
        n_vec++; if (bus.packet[21] !== 16'h0001) begin n_bad++; $display("FAIL max_first: got %h expected 0001", bus.packet[21]); end
        n_vec++; if (bus.packet[67] !== 16'h2E01) begin n_bad++; $display("FAIL max_last: got %h expected 2e01", bus.packet[67]); end
        n_vec++; if (bus.packet[19] !== 16'h6600) begin n_bad++; $display("FAIL max_udp_len: got %h expected 6600", bus.packet[19]); end
        do_ack(1'b0);
    endtask

    task automatic test_toggle();
        int s, c, sent, last;
        bit ok;
        pl[0] = 16'hA1B2; pl[1] = 16'hC3D4; pl[2] = 16'hE5F6;
        bus.pl_valid = 1'b1; bus.pl_data = 16'hBAD0;
        repeat (2) @(negedge clk100);
        bus.pl_valid = 1'b0;
        start_frame(6'd3, s);
        send_payload(3, 1'b1, sent, last);
        n_vec++; if (sent !== 3) begin n_bad++; $display("FAIL tog_sent: got %0d expected 3", sent); end
        wait_cts(c, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL tog_timeout: clear_to_send never rose"); end
        n_vec++; if (c - last !== 12) begin n_bad++; $display("FAIL tog_latency: got %0d expected 12", c - last); end
        n_vec++; if (bus.packet_length !== 16'd60) begin n_bad++; $display("FAIL tog_length: got %0d expected 60", bus.packet_length); end
        n_vec++; if (bus.packet[21] !== 16'hB2A1) begin n_bad++; $display("FAIL tog_w0: got %h expected b2a1", bus.packet[21]); end
        n_vec++; if (bus.packet[22] !== 16'hD4C3) begin n_bad++; $display("FAIL tog_w1: got %h expected d4c3", bus.packet[22]); end
        n_vec++; if (bus.packet[23] !== 16'hF6E5) begin n_bad++; $display("FAIL tog_w2: got %h expected f6e5", bus.packet[23]); end
        for (int k = 24; k <= 29; k++) begin
            n_vec++;
            if (bus.packet[k] !== 16'h0000) begin n_bad++; $display("FAIL tog_pad[%0d]: got %h expected 0000", k, bus.packet[k]); end
        end
        do_ack(1'b0);
    endtask

    task automatic test_back_to_back();
        int s, c, sent, last;
        bit ok;
        frame_t fe;
        apply_reset();
        for (int f = 0; f < 3; f++) begin
            pl[0] = 16'h1000 * 16'(f + 1) + 16'h0011;
            pl[1] = 16'h1000 * 16'(f + 1) + 16'h0022;
            fe = model(2, exp_ip_id);
            start_frame(6'd2, s);
            send_payload(2, 1'b0, sent, last);
            wait_cts(c, ok);
            n_vec++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout[%0d]: clear_to_send never rose", f); end
            n_vec++; if (c - last !== 12) begin n_bad++; $display("FAIL b2b_latency[%0d]: got %0d expected 12", f, c - last); end
            n_vec++; if (bus.packet[9] !== {exp_ip_id[7:0], exp_ip_id[15:8]}) begin
                n_bad++; $display("FAIL b2b_ip_id[%0d]: got %h expected id %0d", f, bus.packet[9], exp_ip_id);
            end
            for (int k = 0; k < 5; k++) begin
                bus.start = (k == 2);
                bus.pl_valid = 1'b1;
                bus.pl_data = 16'hBEEF;
                @(negedge clk100);
                n_vec++; if (bus.clear_to_send !== 1'b1 || bus.busy !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_hold[%0d]: cts=%b busy=%b expected 1/1", f, bus.clear_to_send, bus.busy);
                end
            end
            bus.start = 1'b0;
            bus.pl_valid = 1'b0;
            n_vec++; if (bus.packet[21] !== fe.w[21] || bus.packet[22] !== fe.w[22] || bus.packet[12] !== fe.w[12]) begin
                n_bad++; $display("FAIL b2b_frozen[%0d]: got %h %h %h expected %h %h %h", f,
                    bus.packet[21], bus.packet[22], bus.packet[12], fe.w[21], fe.w[22], fe.w[12]);
            end
            do_ack(1'b1);
            n_vec++; if (bus.clear_to_send !== 1'b0 || bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL b2b_ack[%0d]: cts=%b busy=%b expected 0/0", f, bus.clear_to_send, bus.busy);
            end
            @(negedge clk100);
            n_vec++; if (bus.busy !== 1'b0) begin
                n_bad++; $display("FAIL b2b_start_with_ack[%0d]: busy=%b expected 0", f, bus.busy);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int s, c, sent, last;
        bit ok;
        for (int i = 0; i < 10; i++) pl[i] = 16'h5500 + 16'(i);
        start_frame(6'd10, s);
        send_payload(2, 1'b0, sent, last);
        n_vec++; if (sent !== 2 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL mid_load_state: sent=%0d busy=%b expected 2/1", sent, bus.busy);
        end
        rst = 1'b1;
        @(negedge clk100);
        rst = 1'b0;
        n_vec++; if (bus.clear_to_send !== 1'b0) begin n_bad++; $display("FAIL mid_rst_cts: got %b expected 0", bus.clear_to_send); end
        n_vec++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy: got %b expected 0", bus.busy); end
        n_vec++; if (bus.pl_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b expected 0", bus.pl_ready); end
        sb.delete();
        exp_ip_id = 16'd0;
        for (int i = 0; i < 4; i++) pl[i] = 16'h6600 + 16'(i * 3);
        start_frame(6'd4, s);
        send_payload(4, 1'b0, sent, last);
        wait_cts(c, ok);
        n_vec++; if (!ok) begin n_bad++; $display("FAIL mid_next_timeout: clear_to_send never rose"); end
        n_vec++; if (c - last !== 12) begin n_bad++; $display("FAIL mid_next_latency: got %0d expected 12", c - last); end
        do_ack(1'b0);
    endtask

    task automatic test_saturate();
        int s, c, idx, last, g;
        bit ok;
        for (int i = 0; i < 47; i++) pl[i] = 16'h7700 + 16'(i);
        start_frame(6'd63, s);
        idx = 0; last = 0; g = 0;
        bus.pl_valid = 1'b1;
        while (g < 200) begin
            bus.pl_data = (idx < 47) ? pl[idx] : 16'hDEAD;
            if (bus.pl_ready) begin
                idx++;
                last = cyc;
            end else if (idx > 0) begin
                break;
            end
            @(negedge clk100);
            g++;
        end
        n_vec++; if (idx !== 47) begin n_bad++; $display("FAIL sat_transfers: got %0d expected 47", idx); end
        wait_cts(c, ok);
        bus.pl_valid = 1'b0;
        n_vec++; if (!ok) begin n_bad++; $display("FAIL sat_timeout: clear_to_send never rose"); end
        n_vec++; if (c - last !== 12) begin n_bad++; $display("FAIL sat_latency: got %0d expected 12", c - last); end
        n_vec++; if (bus.packet_length !== 16'd136) begin n_bad++; $display("FAIL sat_length: got %0d expected 136", bus.packet_length); end
        n_vec++; if (bus.packet[67] !== 16'h2E77) begin n_bad++; $display("FAIL sat_last: got %h expected 2e77", bus.packet[67]); end
        do_ack(1'b0);
    endtask

    initial begin
        test_reset();
        test_min_frame();
        test_max_frame();
        test_toggle();
        test_back_to_back();
        test_reset_mid_load();
        test_saturate();
        repeat (2) @(negedge clk100);
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover: %0d expected frames never produced", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
